instr_fetch_stage: RTL

//  MIPS instruction fetch stage, directly upstream of the main control decoder.
//  - Owns the PC and issues word reads to instruction memory over a req/gnt + rvalid interface.
//  - Buffers returned words in a small in-order queue.
//  - Presents instr/pcplus4 plus op = instr[31:26] to decode under a valid/ready handshake.
//  - Accepts branch/jump redirects and discards stale in-flight fetches.

---
 rtl/mips_pkg.sv | 17 +
 rtl/fetch_queue.sv | 56 +++++
 rtl/instr_fetch_stage.sv | 81 ++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: word width, default reset vector, primary opcodes, fetch-queue entry.
package mips_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pcplus4;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// In-order DEPTH-entry instruction queue; head read is zero-latency, push visible next cycle.
// No internal backpressure: the owner must never push while full without a simultaneous pop.
module fetch_queue import mips_pkg::*; #(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  output logic [CW-1:0] occ,
  output fetch_entry_t  head
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (occ != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      if (do_push && !do_pop)      occ <= occ + CW'(1);
      else if (do_pop && !do_push) occ <= occ - CW'(1);
    end
  end

  // Storage needs no reset: occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    do_push |-> (occ != FULL || do_pop));
endmodule

// File: rtl/instr_fetch_stage.sv
// MIPS fetch: owns PC, issues imem reads, queues words for decode. Grant N + rvalid N+k -> if_valid N+k+1.
// Requests stop once queued + outstanding reads reach DEPTH; id_ready low holds the head entry.
module instr_fetch_stage import mips_pkg::*; #(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        id_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pcplus4,
  output logic [5:0]  if_op
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

  logic [31:0]   pc, resp_pc, target;
  logic [CW-1:0] occ, outstanding, drop_cnt, out_after;
  logic          grant, keep, pop;
  fetch_entry_t  push_entry, head;

  assign target    = redirect_pc & 32'hFFFF_FFFC;
  // Dropped responses still hold a credit, so the queue always has room for every return.
  assign imem_req  = reset_n && !redirect && (({1'b0, occ} + {1'b0, outstanding}) < LIMIT);
  assign imem_addr = pc & 32'hFFFF_FFFC;
  assign grant     = imem_req && imem_gnt;
  assign keep      = imem_rvalid && !redirect && (drop_cnt == '0);
  assign out_after = outstanding + CW'(grant) - CW'(imem_rvalid);

  assign if_valid   = (occ != '0) && !redirect;
  assign pop        = if_valid && id_ready;
  assign if_instr   = head.instr;
  assign if_pcplus4 = head.pcplus4;
  assign if_op      = head.instr[31:26];

  assign push_entry.instr   = imem_rdata;
  assign push_entry.pcplus4 = resp_pc + 32'd4;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect) begin
      pc          <= target;
      resp_pc     <= target;
      outstanding <= out_after;
      drop_cnt    <= out_after;
    end else begin
      if (grant) pc <= pc + 32'd4;
      outstanding <= out_after;
      if (imem_rvalid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
      if (keep) resp_pc <= resp_pc + 32'd4;
    end
  end

  fetch_queue #(.DEPTH(DEPTH), .CW(CW)) u_queue (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (redirect),
    .push       (keep),
    .push_entry (push_entry),
    .pop        (pop),
    .occ        (occ),
    .head       (head)
  );

  a_rvalid_credit: assert property (@(posedge clk) disable iff (!reset_n)
    imem_rvalid |-> (outstanding != '0));
  a_addr_hold: assert property (@(posedge clk) disable iff (!reset_n)
    (imem_req && !imem_gnt) |=> $stable(imem_addr));
endmodule
